pcpi_div_liveness_watchdog: RTL and testbench
=============================================

// Module: pcpi_div_liveness_watchdog
// PURPOSE
//  Consumer end of the PCPI divider request/response handshake: observes pcpi_valid-style requests
//  and pcpi_ready-style completions, measures per-transaction latency and flags a timeout when a
//  response does not arrive in bounded time. Sits in the pcpi_div agent alongside the divider; its
//  timeout output feeds bench liveness checks and coverage in place of unbounded-eventually checks.
// PARAMETERS
//  CNT_W        32   width of latency counter and latency outputs
//  TIMEOUT_CYC  40   cycles in WAIT without response before timeout (must be >=1, < 2**CNT_W-1)
// PORTS
//  clk          in   1      rising-edge clock
//  resetn       in   1      synchronous, active-low reset
//  enable       in   1      0: freeze FSM and counter (clear still honoured)
//  req_valid    in   1      request present (held high until response, PCPI rules)
//  rsp_ready    in   1      single-cycle response strobe
//  clear        in   1      clears sticky flags
//  busy         out  1      1 while in WAIT or EXPIRED
//  latency      out  CNT_W  latency of last completed transaction (cycles, saturating)
//  timeout      out  1      sticky: a request exceeded TIMEOUT_CYC
//  timeout_pls  out  1      one-cycle pulse on entry to EXPIRED
//  proto_err    out  1      sticky: req_valid dropped with no response, or rsp_ready with no request
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): state IDLE, cnt=0; all outputs 0. Mid-transaction reset drops it, no latency update.
//  - States IDLE, WAIT, EXPIRED; all transitions require enable=1.
//  - IDLE: req_valid&rsp_ready -> stay IDLE, latency<=0. req_valid only -> WAIT, cnt<=1.
//    rsp_ready only -> proto_err<=1.
//  - WAIT: rsp_ready -> IDLE, latency<=cnt. req_valid=0 & !rsp_ready -> IDLE, proto_err<=1, latency unchanged.
//    else cnt<=cnt+1; if cnt==TIMEOUT_CYC -> EXPIRED, timeout_pls=1 for that cycle, timeout<=1.
//  - EXPIRED: cnt keeps incrementing; rsp_ready -> IDLE, latency<=cnt (late completion still recorded);
//    req_valid=0 & !rsp_ready -> IDLE, proto_err<=1.
//  - Response on exact timeout cycle (cnt==TIMEOUT_CYC & rsp_ready): completion wins, no timeout.
//  - cnt saturates at all-ones, never wraps; latency reports saturated value.
//  - clear=1: timeout<=0, proto_err<=0; if a set condition occurs the same cycle, set wins.
//  - enable=0: state, cnt, latency hold; timeout_pls=0; rsp_ready/req_valid ignored.
//  - Outputs are registered; latency/flags visible the cycle after the triggering edge.
// CONFIGURATION
//  Macro PCPI_WDOG_STATS_EN:
//   defined: adds outputs max_latency[CNT_W] (highest completed latency since reset/clear, saturating)
//            and txn_count[16] (completed transactions, saturating at 16'hFFFF); clear zeroes both.
//   undefined: those ports and registers absent; all other behaviour identical.
// STRUCTURE
//  - pcpi_wdog_pkg: typedef enum logic [1:0] {WD_IDLE, WD_WAIT, WD_EXPIRED} wd_state_e; default CNT_W/TIMEOUT_CYC localparams.
//  - One sub-module: wdog_sat_counter (load-1 / increment / hold, saturating, width-parameterised),
//    reused for cnt and, with stats enabled, txn_count.
// TESTING
//  1. req_valid high at t0, rsp_ready at t0+36 -> latency=36, busy 1 for 36 cycles, timeout=0.
//  2. req_valid held, no response -> timeout_pls one cycle, 40 cycles after req_valid, timeout sticky;
//     rsp_ready at t0+50 -> latency=50, IDLE.
//  3. rsp_ready exactly at cnt==40 -> latency=40, timeout stays 0; req_valid&rsp_ready same cycle in IDLE -> latency=0.
//  4. req_valid dropped at t0+5 without response -> proto_err=1; clear with no new error -> proto_err=0;
//     clear coincident with timeout_pls -> timeout=1.
//  5. enable=0 for 10 cycles mid-WAIT -> latency grows by 0 during freeze; resetn=0 mid-WAIT -> IDLE, outputs 0 next cycle.
//  6. PCPI_WDOG_STATS_EN: latencies 10,30,20 -> max_latency=30, txn_count=3; clear -> both 0.

Source files
------------

// File: rtl/pcpi_wdog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_wdog_pkg
// Brief    : Shared state encoding and default sizing for the PCPI divider
//            liveness watchdog.
// Revision : 1.0 - initial release
// ============================================================================
package pcpi_wdog_pkg;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_WAIT    = 2'd1,
    WD_EXPIRED = 2'd2
  } wd_state_e;

  localparam int unsigned C_DEF_CNT_W       = 32;
  localparam int unsigned C_DEF_TIMEOUT_CYC = 40;

  function automatic logic wd_is_busy(input wd_state_e s);
    return (s != WD_IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wdog_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : wdog_sat_counter
// Brief    : Width-parameterised counter with clear, load-one, saturating
//            increment and hold.
// Revision : 1.0 - initial release
// ============================================================================
module wdog_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] C_MAX = '1;
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // Priority: clear, then load-one, then increment (stops at all-ones).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load1) begin
      r_count <= C_ONE;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pcpi_div_liveness_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_div_liveness_watchdog
// Brief    : Observes PCPI divider request/response, records per-transaction
//            latency and flags timeouts and protocol errors.
//            Optional statistics outputs under macro PCPI_WDOG_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pcpi_div_liveness_watchdog
  import pcpi_wdog_pkg::*;
#(
  parameter int CNT_W       = C_DEF_CNT_W,
  parameter int TIMEOUT_CYC = C_DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             req_valid,
  input  logic             rsp_ready,
  input  logic             clear,
  output logic             busy,
  output logic [CNT_W-1:0] latency,
  output logic             timeout,
  output logic             timeout_pls,
  output logic             proto_err
`ifdef PCPI_WDOG_STATS_EN
  ,
  output logic [CNT_W-1:0] max_latency,
  output logic [15:0]      txn_count
`endif
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);

  wd_state_e        r_state;
  wd_state_e        w_next_state;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_lat_val;

  logic w_cnt_load;
  logic w_cnt_inc;
  logic w_complete;
  logic w_lat_zero;
  logic w_proto;
  logic w_expire;

  logic [CNT_W-1:0] r_latency;
  logic             r_timeout;
  logic             r_timeout_pls;
  logic             r_proto_err;

  wdog_sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (1'b0),
    .load1  (w_cnt_load),
    .inc    (w_cnt_inc),
    .count  (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= WD_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (enable) begin
      case (r_state)
        WD_IDLE: begin
          if (req_valid && !rsp_ready) begin
            w_next_state = WD_WAIT;
          end
        end
        WD_WAIT, WD_EXPIRED: begin
          if (rsp_ready || !req_valid) begin
            w_next_state = WD_IDLE;
          end else if ((r_state == WD_WAIT) && (w_cnt == C_TIMEOUT)) begin
            w_next_state = WD_EXPIRED;
          end
        end
        default: w_next_state = WD_IDLE;
      endcase
    end
  end

  // Event decode; a response on the exact timeout cycle is a completion.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_inc  = 1'b0;
    w_complete = 1'b0;
    w_lat_zero = 1'b0;
    w_proto    = 1'b0;
    w_expire   = 1'b0;
    if (enable) begin
      case (r_state)
        WD_IDLE: begin
          if (req_valid && rsp_ready) begin
            w_complete = 1'b1;
            w_lat_zero = 1'b1;
          end else if (req_valid) begin
            w_cnt_load = 1'b1;
          end else if (rsp_ready) begin
            w_proto = 1'b1;
          end
        end
        WD_WAIT, WD_EXPIRED: begin
          if (rsp_ready) begin
            w_complete = 1'b1;
          end else if (!req_valid) begin
            w_proto = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
            w_expire  = (r_state == WD_WAIT) && (w_cnt == C_TIMEOUT);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_lat_val = w_lat_zero ? '0 : w_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_latency     <= '0;
      r_timeout     <= 1'b0;
      r_timeout_pls <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_timeout_pls <= w_expire;
      if (w_complete) begin
        r_latency <= w_lat_val;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end else if (clear) begin
        r_timeout <= 1'b0;
      end
      if (w_proto) begin
        r_proto_err <= 1'b1;
      end else if (clear) begin
        r_proto_err <= 1'b0;
      end
    end
  end

  assign busy        = wd_is_busy(r_state);
  assign latency     = r_latency;
  assign timeout     = r_timeout;
  assign timeout_pls = r_timeout_pls;
  assign proto_err   = r_proto_err;

`ifdef PCPI_WDOG_STATS_EN
  logic [CNT_W-1:0] r_max_latency;
  logic [15:0]      w_txn_count;

  // A completion coinciding with clear restarts the statistics from it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_max_latency <= '0;
    end else if (w_complete && (clear || (w_lat_val > r_max_latency))) begin
      r_max_latency <= w_lat_val;
    end else if (clear) begin
      r_max_latency <= '0;
    end
  end

  wdog_sat_counter #(.WIDTH(16)) u_txn_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear && !w_complete),
    .load1  (clear && w_complete),
    .inc    (w_complete),
    .count  (w_txn_count)
  );

  assign max_latency = r_max_latency;
  assign txn_count   = w_txn_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcpi_div_liveness_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcpi_div_liveness_watchdog
// Brief    : Directed self-checking bench for the PCPI liveness watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcpi_div_liveness_watchdog;

  logic        clk = 1'b0;
  logic        resetn, enable, req_valid, rsp_ready, clear;
  logic        busy, timeout, timeout_pls, proto_err;
  logic [31:0] latency;
  logic        busy_s, timeout_s, timeout_pls_s, proto_err_s;
  logic [5:0]  latency_s;
`ifdef PCPI_WDOG_STATS_EN
  logic [31:0] max_latency;
  logic [15:0] txn_count;
  logic [5:0]  max_latency_s;
  logic [15:0] txn_count_s;
`endif

  int errors = 0;
  int checks = 0;
  int busy_cycles;
  int pls_seen;

  always #5 clk = ~clk;

  pcpi_div_liveness_watchdog #(.CNT_W(32), .TIMEOUT_CYC(40)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .req_valid   (req_valid),
    .rsp_ready   (rsp_ready),
    .clear       (clear),
    .busy        (busy),
    .latency     (latency),
    .timeout     (timeout),
    .timeout_pls (timeout_pls),
    .proto_err   (proto_err)
`ifdef PCPI_WDOG_STATS_EN
    ,
    .max_latency (max_latency),
    .txn_count   (txn_count)
`endif
  );

  // Narrow instance sharing the stimulus, used to observe saturation.
  pcpi_div_liveness_watchdog #(.CNT_W(6), .TIMEOUT_CYC(10)) dut_s (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .req_valid   (req_valid),
    .rsp_ready   (rsp_ready),
    .clear       (clear),
    .busy        (busy_s),
    .latency     (latency_s),
    .timeout     (timeout_s),
    .timeout_pls (timeout_pls_s),
    .proto_err   (proto_err_s)
`ifdef PCPI_WDOG_STATS_EN
    ,
    .max_latency (max_latency_s),
    .txn_count   (txn_count_s)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Request at edge t0, response at edge t0+n.
  task automatic run_txn(input int n);
    req_valid = 1'b1;
    step();
    repeat (n - 1) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; clear = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_latency", latency, 0);
    check("rst_timeout", timeout, 0);
    check("rst_pls", timeout_pls, 0);
    check("rst_proto", proto_err, 0);
    resetn = 1'b1;
    step();

    // 1: latency 36
    req_valid = 1'b1;
    busy_cycles = 0;
    repeat (36) begin
      step();
      if (busy) busy_cycles++;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("t1_busy_cycles", busy_cycles, 36);
    check("t1_latency", latency, 36);
    check("t1_busy_after", busy, 0);
    check("t1_timeout", timeout, 0);

    // 2: timeout then late completion at 50
    req_valid = 1'b1;
    step();
    pls_seen = 0;
    repeat (39) begin
      step();
      if (timeout_pls) pls_seen++;
    end
    check("t2_no_early_pls", pls_seen, 0);
    step();
    check("t2_pls", timeout_pls, 1);
    check("t2_timeout", timeout, 1);
    check("t2_busy_expired", busy, 1);
    step();
    check("t2_pls_one_cycle", timeout_pls, 0);
    check("t2_timeout_sticky", timeout, 1);
    repeat (8) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("t2_latency", latency, 50);
    check("t2_idle", busy, 0);
    check("t2_timeout_held", timeout, 1);

    // 3: response exactly on the timeout cycle; same-cycle req/rsp
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t3_cleared", timeout, 0);
    run_txn(40);
    check("t3_latency40", latency, 40);
    check("t3_no_timeout", timeout, 0);
    req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("t3_latency0", latency, 0);
    check("t3_busy0", busy, 0);

    // 4: protocol errors and clear
    req_valid = 1'b1;
    step();
    repeat (4) step();
    req_valid = 1'b0;
    step();
    check("t4_proto_drop", proto_err, 1);
    check("t4_drop_idle", busy, 0);
    check("t4_drop_latency", latency, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4_proto_clear", proto_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t4_proto_rsp_only", proto_err, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    req_valid = 1'b1;
    step();
    repeat (39) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4_clr_pls", timeout_pls, 1);
    check("t4_set_wins", timeout, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("t4_latency41", latency, 41);

    // 5: freeze mid-WAIT, then reset mid-WAIT
    req_valid = 1'b1;
    step();
    repeat (4) step();
    enable = 1'b0;
    repeat (5) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t5_freeze_busy", busy, 1);
    check("t5_freeze_latency", latency, 41);
    repeat (4) step();
    enable = 1'b1;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("t5_latency_frozen", latency, 5);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t5_proto_pre_rst", proto_err, 1);
    req_valid = 1'b1;
    step();
    repeat (3) step();
    resetn = 1'b0;
    step();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_latency", latency, 0);
    check("t5_rst_timeout", timeout, 0);
    check("t5_rst_proto", proto_err, 0);
    resetn = 1'b1; req_valid = 1'b0;
    step();

    // Saturation on the narrow instance
    run_txn(70);
    check("sat_wide_latency", latency, 70);
    check("sat_narrow_latency", latency_s, 63);
    check("sat_narrow_timeout", timeout_s, 1);

`ifdef PCPI_WDOG_STATS_EN
    // 6: statistics
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t6_txn_cleared", txn_count, 0);
    run_txn(10);
    run_txn(30);
    run_txn(20);
    check("t6_max_latency", max_latency, 30);
    check("t6_txn_count", txn_count, 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t6_max_clear", max_latency, 0);
    check("t6_txn_clear", txn_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
